alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and power-aware sequencer that shares one registered ALU among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and select inputs. It captures the result and flags after a fixed latency and returns them tagged with the requester ID. It also generates the `idle` input of the PMU: it asserts `idle` after a programmable run of empty cycles, and holds off issue for a wake-up interval when work arrives.

## Interface
- `WIDTH`, 32, operand/result width.
- `NREQ`, 4, number of requesters (≥2); `IW = $clog2(NREQ)`.
- `LAT`, 1, cycles from operands stable at the ALU inputs to a valid `alu_result` (≥1).
- `WAKE_CYC`, 4, cycles to wait after `idle` deasserts before the first issue (≥1).
- `IDLE_CYC`, 16, consecutive empty arbitration cycles before `idle` asserts (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  one-hot grant/accept.
- `req_A`, `req_B`  in  NREQ*WIDTH  packed operands; slice i belongs to requester i.
- `req_sel`  in  NREQ*4  packed ALU select.
- `req_cin`  in  NREQ  carry-in.
- `alu_A`, `alu_B`  out  WIDTH  registered operands to the ALU.
- `alu_sel`  out  4  registered ALU select.
- `alu_cin`  out  1  registered carry-in.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags`  in  5  {Zero, CarryOut, Overflow, Negative, Less}.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  IW  index of the requester served.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_flags`  out  5  captured flags.
- `idle`  out  1  registered power-down request to the PMU.

## Operation
- The FSM has four states: SLEEP, WAKE, ARB, BUSY. Reset enters SLEEP.
- **SLEEP**
  - `idle`=1, `req_ready`=0.
  - Any `req_valid` → WAKE.
  - Entering WAKE deasserts `idle` and loads the wake counter.
- **WAKE**
  - `idle`=0, `req_ready`=0.
  - Stays for exactly `WAKE_CYC` cycles, then → ARB.
  - Requests are not granted in WAKE.
- **ARB**
  - If any `req_valid`, grant the first valid requester at or after `ptr`, searching upward and wrapping. `req_ready` for the winner is combinational in this cycle, and the handshake completes this cycle.
  - On grant: latch the winner's slice into the `alu_*` registers and its index into `rsp_id`; set `ptr` to winner+1 mod NREQ; clear the idle counter; go to BUSY.
  - With no valid request: increment the idle counter. When this is the `IDLE_CYC`-th consecutive empty ARB cycle, go to SLEEP (`idle`=1 next cycle).
- **BUSY**
  - `req_ready`=0. Stays LAT+1 cycles: one for the ALU input register, LAT for the ALU.
  - On the last BUSY cycle, capture `alu_result`/`alu_flags` into the `rsp_*` registers and go to ARB.
  - `rsp_valid` is high for the single following cycle.
- Requester rules:
  - A requester holds `req_valid` and its payload stable until it sees `req_ready`.
  - Dropping `req_valid` before grant is legal; that request is simply not served.
- `alu_*` and `rsp_result`/`rsp_flags`/`rsp_id` hold their last values between operations.
- Only one operation is ever in flight.

## Timing
- Reset values:
  - `idle`=1, `req_ready`=0, `rsp_valid`=0.
  - `alu_A`/`alu_B`/`alu_sel`/`alu_cin`=0.
  - `rsp_id`/`rsp_result`/`rsp_flags`=0.
  - `ptr`=0, so requester 0 has highest priority first.
  - Idle counter and wake counter = 0.
- Grant in cycle t: `alu_*` updated from t+1, result sampled at the end of t+LAT+1, `rsp_valid` at t+LAT+2.
  - That cycle is also ARB, so back-to-back grants occur every LAT+2 cycles.
- Cold start: valid at cycle 0 in SLEEP → `idle`=0 at 1 → WAKE cycles 1..WAKE_CYC → first possible grant at WAKE_CYC+1.
- A request present in the cycle the idle counter would expire wins: it is granted, there is no SLEEP transition, and `idle` stays 0.
- Reset mid-operation, in any state: the in-flight operation is dropped, there is no `rsp_valid`, and all outputs return immediately to their reset values.

## Test plan
- **Reset / quiescence:** assert `rst`, release, no requests → `idle`=1, `req_ready`=0, `rsp_valid`=0, all `alu_*`=0, held indefinitely.
- **Cold start (defaults):**
  - Stimulus: req0 valid at cycle 0 with A=5, B=3, sel=ADD, cin=0.
  - Response: `idle`=0 at 1; `req_ready[0]`=1 at 5; `alu_A`=5 at 6; `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8 at 8.
- **Round-robin fairness:**
  - Stimulus: all 4 requesters valid continuously from ARB.
  - Response: grants 0,1,2,3,0, each 3 cycles apart; `rsp_id` sequence matches.
- **Wrap and skip:**
  - Stimulus: only req3 and req1 valid, `ptr`=2.
  - Response: grants 3, then 1, then 3.
- **Idle entry / collision:**
  - After the last response with no requests, `idle` rises after exactly 16 empty ARB cycles.
  - Repeat with a request arriving on the 16th empty cycle → granted, `idle` stays 0.
- **Reset mid-BUSY:**
  - Stimulus: assert `rst` one cycle after a grant.
  - Response: no `rsp_valid`, `idle`=1, `alu_*`=0 immediately, and a full WAKE sequence is required afterward.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU among NREQ requesters and
// drives the PMU idle request (sleep after a run of empty cycles, wake-up delay on new work).
module alu_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LAT      = 1,
  parameter int unsigned WAKE_CYC = 4,
  parameter int unsigned IDLE_CYC = 16,
  localparam int unsigned IW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_A,
  input  logic [NREQ*WIDTH-1:0] req_B,
  input  logic [NREQ*4-1:0]     req_sel,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      alu_A,
  output logic [WIDTH-1:0]      alu_B,
  output logic [3:0]            alu_sel,
  output logic                  alu_cin,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [4:0]            alu_flags,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [4:0]            rsp_flags,
  output logic                  idle
);

  localparam logic [1:0] SLEEP = 2'd0;
  localparam logic [1:0] WAKE  = 2'd1;
  localparam logic [1:0] ARB   = 2'd2;
  localparam logic [1:0] BUSY  = 2'd3;

  localparam int unsigned WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam int unsigned BW = $clog2(LAT + 1);
  localparam int unsigned IC = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wake_q, wake_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [IC-1:0] idle_cnt_q, idle_cnt_d;

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   cand;
  logic          grant;
  logic          capture;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!grant_found && req_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  assign grant   = (state_q == ARB) && grant_found;
  assign capture = (state_q == BUSY) && (busy_q == '0);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wake_d     = wake_q;
    busy_d     = busy_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      SLEEP: begin
        if (|req_valid) begin
          state_d = WAKE;
          wake_d  = WW'(WAKE_CYC - 1);
        end
      end
      WAKE: begin
        if (wake_q == '0) state_d = ARB;
        else              wake_d  = wake_q - 1'b1;
      end
      ARB: begin
        if (grant_found) begin
          state_d    = BUSY;
          busy_d     = BW'(LAT);
          idle_cnt_d = '0;
          ptr_d      = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (idle_cnt_q == IC'(IDLE_CYC - 1)) begin
          state_d    = SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      BUSY: begin
        // One cycle for the ALU input register, then LAT for the ALU itself.
        if (busy_q == '0) state_d = ARB;
        else              busy_d  = busy_q - 1'b1;
      end
      default: state_d = SLEEP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SLEEP;
      ptr_q      <= '0;
      wake_q     <= '0;
      busy_q     <= '0;
      idle_cnt_q <= '0;
      idle       <= 1'b1;
      rsp_valid  <= 1'b0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_sel    <= '0;
      alu_cin    <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wake_q     <= wake_d;
      busy_q     <= busy_d;
      idle_cnt_q <= idle_cnt_d;
      idle       <= (state_d == SLEEP);
      rsp_valid  <= capture;
      if (grant) begin
        alu_A   <= req_A[grant_idx*WIDTH +: WIDTH];
        alu_B   <= req_B[grant_idx*WIDTH +: WIDTH];
        alu_sel <= req_sel[grant_idx*4 +: 4];
        alu_cin <= req_cin[grant_idx];
        rsp_id  <= grant_idx;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: cold start, round-robin, wrap/skip, idle entry,
// idle/request collision and reset during BUSY, against a small registered ALU model.
module tb_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_A = '0;
  logic [NREQ*WIDTH-1:0] req_B = '0;
  logic [NREQ*4-1:0]     req_sel = '0;
  logic [NREQ-1:0]       req_cin = '0;
  logic [WIDTH-1:0]      alu_A, alu_B;
  logic [3:0]            alu_sel;
  logic                  alu_cin;
  logic [WIDTH-1:0]      alu_result = '0;
  logic [4:0]            alu_flags = '0;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic [4:0]            rsp_flags;
  logic                  idle;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_sel    (req_sel),
    .req_cin    (req_cin),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_sel    (alu_sel),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Registered ALU, one cycle latency. sel: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  logic [32:0] sum_c;
  logic [4:0]  flg_c;
  always_comb begin
    sum_c = '0;
    case (alu_sel)
      4'd0:    sum_c = {1'b0, alu_A} + {1'b0, alu_B} + {32'd0, alu_cin};
      4'd1:    sum_c = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
      4'd2:    sum_c = {1'b0, alu_A & alu_B};
      4'd3:    sum_c = {1'b0, alu_A | alu_B};
      default: sum_c = {1'b0, alu_A ^ alu_B};
    endcase
    flg_c[4] = (sum_c[31:0] == 32'd0);
    flg_c[3] = (alu_sel <= 4'd1) ? sum_c[32] : 1'b0;
    flg_c[2] = (alu_sel == 4'd0) ? ((alu_A[31] == alu_B[31]) && (sum_c[31] != alu_A[31])) :
               (alu_sel == 4'd1) ? ((alu_A[31] != alu_B[31]) && (sum_c[31] != alu_A[31])) : 1'b0;
    flg_c[1] = sum_c[31];
    flg_c[0] = ($signed(alu_A) < $signed(alu_B));
  end

  always @(posedge clk) begin
    alu_result <= sum_c[31:0];
    alu_flags  <= flg_c;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic cin);
    req_A[i*WIDTH +: WIDTH] = a;
    req_B[i*WIDTH +: WIDTH] = b;
    req_sel[i*4 +: 4]       = sel;
    req_cin[i]              = cin;
  endtask

  // Called in the expected grant cycle; returns in the response cycle (next ARB cycle).
  task automatic serve(input int id, input logic [31:0] a, input logic [31:0] res,
                       input logic [4:0] flg, input logic [3:0] nxt);
    logic [3:0] onehot;
    onehot = 4'(1 << id);
    check_eq("grant", 64'(req_ready), 64'(onehot));
    tick();
    req_valid = nxt;
    check_eq("alu_A", 64'(alu_A), 64'(a));
    check_eq("idle_busy", 64'(idle), 64'd0);
    tick();
    check_eq("rsp_early", 64'(rsp_valid), 64'd0);
    check_eq("ready_busy", 64'(req_ready), 64'd0);
    tick();
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_id", 64'(rsp_id), 64'(id));
    check_eq("rsp_result", 64'(rsp_result), 64'(res));
    check_eq("rsp_flags", 64'(rsp_flags), 64'(flg));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic seen;
    // Reset and quiescence
    do_reset();
    repeat (20) tick();
    check_eq("q_idle", 64'(idle), 64'd1);
    check_eq("q_ready", 64'(req_ready), 64'd0);
    check_eq("q_rsp", 64'(rsp_valid), 64'd0);
    check_eq("q_alu", {alu_A, alu_B}, 64'd0);
    check_eq("q_sel_cin", 64'({alu_sel, alu_cin}), 64'd0);
    check_eq("q_rsp_regs", 64'({rsp_id, rsp_result, rsp_flags}), 64'd0);

    // Cold start: 5 + 3
    set_req(0, 32'd5, 32'd3, 4'd0, 1'b0);
    req_valid = 4'b0001;
    #1;
    check_eq("cs_idle0", 64'(idle), 64'd1);
    check_eq("cs_ready0", 64'(req_ready), 64'd0);
    tick();
    check_eq("cs_idle1", 64'(idle), 64'd0);
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (req_ready != '0) seen = 1'b1;
      if (k < 4) tick();
    end
    check_eq("cs_no_grant_wake", 64'(seen), 64'd0);
    tick();
    serve(0, 32'd5, 32'd8, 5'b00000, 4'b0000);

    // Round-robin with all requesters valid, then wrap/skip with only 3 and 1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(10 + i), 32'(i), 4'd0, 1'b0);
    req_valid = 4'b1111;
    repeat (5) tick();
    serve(0, 32'd10, 32'd10, 5'b0, 4'b1111);
    serve(1, 32'd11, 32'd12, 5'b0, 4'b1111);
    serve(2, 32'd12, 32'd14, 5'b0, 4'b1111);
    serve(3, 32'd13, 32'd16, 5'b0, 4'b1111);
    serve(0, 32'd10, 32'd10, 5'b0, 4'b1111);
    serve(1, 32'd11, 32'd12, 5'b0, 4'b1010);
    serve(3, 32'd13, 32'd16, 5'b0, 4'b1010);
    serve(1, 32'd11, 32'd12, 5'b0, 4'b1010);
    serve(3, 32'd13, 32'd16, 5'b0, 4'b0000);

    // Idle entry after 16 empty ARB cycles
    repeat (15) tick();
    check_eq("idle_15", 64'(idle), 64'd0);
    tick();
    check_eq("idle_16", 64'(idle), 64'd1);
    check_eq("idle_ready", 64'(req_ready), 64'd0);

    // Collision: request on the 16th empty cycle wins
    req_valid = 4'b0001;
    repeat (5) tick();
    serve(0, 32'd10, 32'd10, 5'b0, 4'b0000);
    repeat (15) tick();
    req_valid = 4'b0010;
    #1;
    check_eq("col_idle", 64'(idle), 64'd0);
    serve(1, 32'd11, 32'd12, 5'b0, 4'b0000);

    // Reset one cycle after a grant
    req_valid = 4'b0100;
    #1;
    check_eq("rb_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check_eq("rb_alu_pre", 64'(alu_A), 64'd12);
    rst = 1'b1;
    #1;
    check_eq("rb_idle", 64'(idle), 64'd1);
    check_eq("rb_alu", {alu_A, alu_B}, 64'd0);
    check_eq("rb_sel_cin", 64'({alu_sel, alu_cin}), 64'd0);
    check_eq("rb_rsp_regs", 64'({rsp_id, rsp_result, rsp_flags}), 64'd0);
    check_eq("rb_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check_eq("rb_no_rsp", 64'(seen), 64'd0);
    check_eq("rb_idle_hold", 64'(idle), 64'd1);

    // Full wake sequence again, with a subtraction 3 - 5
    set_req(0, 32'd3, 32'd5, 4'd1, 1'b0);
    req_valid = 4'b0001;
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (req_ready != '0) seen = 1'b1;
    end
    check_eq("rb_wake_no_grant", 64'(seen), 64'd0);
    tick();
    serve(0, 32'd3, 32'hFFFF_FFFE, 5'b00011, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
